// File: rtl/pet_pkg.sv
// Shared state encoding, food colour range and saturating level helpers for pet_need_engine.
package pet_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_SLEEP  = 2'd2,
    ST_DEAD   = 2'd3
  } pet_state_e;

  localparam logic [2:0] FOOD_MIN = 3'd1;
  localparam logic [2:0] FOOD_MAX = 3'd6;

  // Levels are carried in 8 bits here so any LVL_W up to 8 can share these helpers.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] max_v);
    return (v >= max_v) ? max_v : v + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

endpackage

// File: rtl/pet_decay_ticker.sv
// Decay timer: counts 0..(BASE_INTERVAL >> time_ctrl) while enabled and strobes tick at the top.
module pet_decay_ticker #(
  parameter logic [33:0] BASE_INTERVAL = 34'd4294967295
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] time_ctrl_i,
  output logic       tick_o
);

  logic [33:0] interval;
  logic [33:0] timer_q, timer_d;

  // >= rather than == so a speed-up mid-interval wraps at once instead of running to 2^34.
  always_comb begin
    interval = BASE_INTERVAL >> time_ctrl_i;
    tick_o   = en_i && (timer_q >= interval);
    timer_d  = timer_q + 34'd1;
    if (!en_i || tick_o) timer_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) timer_q <= '0;
    else         timer_q <= timer_d;
  end

endmodule

// File: rtl/pet_need_engine.sv
// Virtual-pet need engine: per-need levels, decay ticks, sleep and death state machine.
// Optional PET_TEST_MODE_EN adds a test input that disables death and makes act a wrapping +1.
module pet_need_engine
  import pet_pkg::*;
#(
  parameter int          N_NEEDS       = 5,
  parameter int          LVL_W         = 3,
  parameter int          LVL_INIT      = 5,
  parameter logic [33:0] BASE_INTERVAL = 34'd4294967295,
  parameter int          DEATH_SUM     = 5,
  parameter int          FEED_IDX      = 1,
  parameter int          REST_IDX      = 2,
  parameter int          PLAY_IDX      = 3,
  parameter int          HEALTH_IDX    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
`ifdef PET_TEST_MODE_EN
  input  logic                       test,
`endif
  input  logic                       btn_next,
  input  logic                       btn_act,
  input  logic                       btn_prev,
  input  logic [1:0]                 time_ctrl,
  input  logic                       light_n,
  input  logic [2:0]                 color,
  output logic [N_NEEDS*LVL_W-1:0]   need_lvl,
  output logic [2:0]                 sel_idx,
  output logic [LVL_W-1:0]           sel_lvl,
  output logic [1:0]                 state_code,
  output logic                       tick
);

  localparam int               SUM_W      = LVL_W + 3;
  localparam logic [LVL_W-1:0] LVL_MAX    = '1;
  localparam logic [LVL_W-1:0] LVL_INIT_V = LVL_W'(LVL_INIT);
  localparam logic [SUM_W-1:0] DEATH_TH   = SUM_W'(DEATH_SUM);
  localparam logic [2:0]       FEED_SEL   = 3'(FEED_IDX);
  localparam logic [2:0]       REST_SEL   = 3'(REST_IDX);
  localparam logic [2:0]       PLAY_SEL   = 3'(PLAY_IDX);
  localparam logic [2:0]       LAST_SEL   = 3'(N_NEEDS - 1);

  function automatic logic [LVL_W-1:0] lvl_inc(input logic [LVL_W-1:0] v);
    return LVL_W'(sat_inc(8'(v), 8'(LVL_MAX)));
  endfunction

  function automatic logic [LVL_W-1:0] lvl_dec(input logic [LVL_W-1:0] v);
    return LVL_W'(sat_dec(8'(v)));
  endfunction

  pet_state_e       state_q, state_d;
  logic [LVL_W-1:0] lvl_q [N_NEEDS];
  logic [LVL_W-1:0] lvl_d [N_NEEDS];
  logic [LVL_W-1:0] base  [N_NEEDS];
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       food_q, food_d;
  logic [1:0]       slp_q, slp_d;
  logic [SUM_W-1:0] sum;
  logic             test_en;
  logic             any_btn;

`ifdef PET_TEST_MODE_EN
  assign test_en = test;
`else
  assign test_en = 1'b0;
`endif

  pet_decay_ticker #(
    .BASE_INTERVAL(BASE_INTERVAL)
  ) u_ticker (
    .clk_i       (clk),
    .rst_ni      (reset),
    .en_i        (state_q != ST_INIT),
    .time_ctrl_i (time_ctrl),
    .tick_o      (tick)
  );

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < N_NEEDS; i++) sum = sum + SUM_W'(lvl_q[i]);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    food_d  = food_q;
    slp_d   = slp_q;
    any_btn = btn_next | btn_act | btn_prev;
    for (int unsigned i = 0; i < N_NEEDS; i++) begin
      base[i]  = lvl_q[i];
      lvl_d[i] = lvl_q[i];
    end

    case (state_q)
      ST_INIT: if (any_btn) state_d = ST_ACTIVE;

      ST_ACTIVE: begin
        if (!test_en && (sum < DEATH_TH)) begin
          state_d = ST_DEAD;
        end else begin
          // Actions see the post-decay value so a same-cycle tick and act both land.
          for (int unsigned i = 0; i < N_NEEDS; i++) begin
            base[i]  = tick ? lvl_dec(lvl_q[i]) : lvl_q[i];
            lvl_d[i] = base[i];
          end
          if (btn_act) begin
            if (test_en) begin
              lvl_d[sel_q] = base[sel_q] + 1'b1;
            end else if (sel_q == FEED_SEL) begin
              if (color == food_q) begin
                lvl_d[FEED_IDX] = lvl_inc(base[FEED_IDX]);
              end else begin
                lvl_d[FEED_IDX]   = lvl_dec(base[FEED_IDX]);
                lvl_d[HEALTH_IDX] = lvl_dec(base[HEALTH_IDX]);
              end
              food_d = (food_q == FOOD_MAX) ? FOOD_MIN : food_q + 3'd1;
            end else if (sel_q == PLAY_SEL) begin
              if ((base[PLAY_IDX] != LVL_MAX) && (base[FEED_IDX] != '0) && (base[REST_IDX] != '0)) begin
                lvl_d[PLAY_IDX] = base[PLAY_IDX] + 1'b1;
                lvl_d[FEED_IDX] = base[FEED_IDX] - 1'b1;
                lvl_d[REST_IDX] = base[REST_IDX] - 1'b1;
              end
            end else if (sel_q == REST_SEL) begin
              if (light_n) state_d = ST_SLEEP;
            end else begin
              lvl_d[sel_q] = lvl_inc(base[sel_q]);
            end
          end else if (btn_next) begin
            sel_d = (sel_q == LAST_SEL) ? 3'd0 : sel_q + 3'd1;
          end else if (btn_prev) begin
            sel_d = (sel_q == 3'd0) ? LAST_SEL : sel_q - 3'd1;
          end
        end
      end

      ST_SLEEP: begin
        if (btn_next || btn_prev || !light_n || (lvl_q[REST_IDX] == LVL_MAX)) begin
          state_d = ST_ACTIVE;
          slp_d   = '0;
        end else if (tick) begin
          slp_d = slp_q + 2'd1;
          if (slp_q == 2'd3) begin
            lvl_d[REST_IDX]   = LVL_MAX;
            lvl_d[HEALTH_IDX] = lvl_inc(lvl_q[HEALTH_IDX]);
          end
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      sel_q   <= '0;
      food_q  <= FOOD_MIN;
      slp_q   <= '0;
      for (int unsigned i = 0; i < N_NEEDS; i++) lvl_q[i] <= LVL_INIT_V;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      food_q  <= food_d;
      slp_q   <= slp_d;
      for (int unsigned i = 0; i < N_NEEDS; i++) lvl_q[i] <= lvl_d[i];
    end
  end

  always_comb begin
    need_lvl = '0;
    for (int unsigned i = 0; i < N_NEEDS; i++) need_lvl[i*LVL_W +: LVL_W] = lvl_q[i];
  end

  assign sel_idx    = sel_q;
  assign state_code = state_q;
  assign sel_lvl    = ((state_q == ST_ACTIVE) || (state_q == ST_SLEEP)) ? lvl_q[sel_q] : '0;

endmodule

// File: doc/pet_need_engine.md
PET_NEED_ENGINE -- requirements
Module: pet_need_engine

Interface
REQ-001 Parameter N_NEEDS, default 5, number of need channels (2..8).
REQ-002 Parameter LVL_W, default 3, bits per need level; LVL_MAX = 2^LVL_W-1.
REQ-003 Parameter LVL_INIT, default 5, level loaded into every need in INIT.
REQ-004 Parameter BASE_INTERVAL, default 34'd4294967295, decay period in clk cycles at time_ctrl=0.
REQ-005 Parameter DEATH_SUM, default 5, death threshold on level sum.
REQ-006 Parameters FEED_IDX=1, REST_IDX=2, PLAY_IDX=3, HEALTH_IDX=4, distinct, each < N_NEEDS.
REQ-007 clk  input  1  single clock, all logic on rising edge.
REQ-008 reset  input  1  asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-009 btn_next / btn_act / btn_prev  input  1 each  single-cycle pulses, debounced upstream.
REQ-010 time_ctrl  input  2  decay speed select.
REQ-011 light_n  input  1  1 = dark, 0 = light.
REQ-012 color  input  3  food colour code from sensor.
REQ-013 need_lvl  output  N_NEEDS*LVL_W  all levels flattened, need i at [i*LVL_W +: LVL_W].
REQ-014 sel_idx  output  3  currently selected need; sel_lvl  output  LVL_W  level of selected need.
REQ-015 state_code  output  2  INIT=0, ACTIVE=1, SLEEP=2, DEAD=3; tick  output  1  one-cycle decay strobe.

Function
REQ-016 Interval = BASE_INTERVAL >> time_ctrl; timer counts 0..interval in INIT-excluded states, tick=1 on cycle timer==interval, timer then wraps to 0.
REQ-017 INIT: levels=LVL_INIT, sel_idx=0, timer=0, food_exp=1; any button pulse -> ACTIVE next cycle, that pulse has no other effect.
REQ-018 ACTIVE button priority per cycle: btn_act > btn_next > btn_prev; lower-priority pulses that cycle are dropped.
REQ-019 btn_next: sel_idx = (sel_idx==N_NEEDS-1) ? 0 : sel_idx+1; btn_prev wraps 0 -> N_NEEDS-1.
REQ-020 ACTIVE tick: every level saturating-decrements by 1 (floor 0).
REQ-021 btn_act on generic need: level +1, saturating at LVL_MAX.
REQ-022 btn_act on FEED_IDX: color==food_exp -> feed +1 sat; else feed -1 sat and health -1 sat; food_exp advances 1..6, 6 wraps to 1, on every feed act.
REQ-023 btn_act on PLAY_IDX: only if play<LVL_MAX and feed>0 and rest>0: play +1, feed -1, rest -1; else no change.
REQ-024 btn_act on REST_IDX with light_n=1 -> SLEEP next cycle, levels unchanged; with light_n=0 ignored.
REQ-025 Tick and act same cycle: action applied to post-decay value, each result saturated to 0..LVL_MAX.
REQ-026 Level sum width LVL_W+3, no overflow; ACTIVE and sum<DEATH_SUM -> DEAD next cycle, overriding any button.
REQ-027 SLEEP: no decay; ticks counted mod 4; 4th tick sets rest=LVL_MAX and health +1 sat.
REQ-028 SLEEP exit to ACTIVE next cycle on btn_next, btn_prev, light_n=0, or rest==LVL_MAX; sel_idx unchanged, sleep tick count cleared.
REQ-029 DEAD: levels frozen, buttons ignored, leave only via reset.
REQ-030 sel_lvl = level[sel_idx] in ACTIVE and SLEEP, 0 in INIT and DEAD.

Reset
REQ-031 reset=0: state INIT, levels LVL_INIT, sel_idx 0, timer 0, tick 0, food_exp 1, sleep count 0; sel_lvl 0, state_code 0.
REQ-032 Reset mid-SLEEP or mid-interval discards all progress; first tick after release occurs interval+1 cycles after entering ACTIVE.

Configuration
REQ-033 Macro PET_TEST_MODE_EN defined: input test (1 bit) added; test=1 disables death transition and saturation-to-floor penalties, btn_act adds +1 with wrap to any need; undefined: port absent, behaviour as REQ-016..030.

Structure
REQ-034 Package pet_pkg holds state enum, state_code values, food colour range constants, saturating inc/dec functions.
REQ-035 Sub-module pet_decay_ticker implements timer, interval shift and tick strobe.

Verification (bench BASE_INTERVAL=7, defaults otherwise)
REQ-036 Reset release, btn_next -> ACTIVE, all levels 5; after 8 cycles tick, all levels 4.
REQ-037 sel_idx=4, btn_next -> sel_idx 0; btn_prev -> 4; btn_act+btn_next same cycle -> health +1, sel_idx stays 4.
REQ-038 Select feed, color=1 act -> feed +1, food_exp 2; color=5 act -> feed -1, health -1, food_exp 3.
REQ-039 Select rest, light_n=1, act -> SLEEP; after 4 ticks rest=7, health +1, state back to ACTIVE.
REQ-040 No input, levels decay to sum 4 -> DEAD next cycle; buttons ignored; reset=0 -> INIT, levels 5.
REQ-041 time_ctrl=3 -> interval 0, tick every cycle; play at 7 act -> no change.
